// File: rtl/nw_pkg.sv
// Shared codes for the alignment read-back path: column directions,
// coordinate field positions inside a memory word, and reader FSM states.
package nw_pkg;

  localparam int unsigned DIR_W = 2;

  localparam logic [DIR_W-1:0] TOP_DIR    = 2'b00;
  localparam logic [DIR_W-1:0] LEFT_DIR   = 2'b01;
  localparam logic [DIR_W-1:0] CORNER_DIR = 2'b10;

  // Field index of each coordinate; field k sits at [k*CORD_LENGTH +: CORD_LENGTH].
  localparam int unsigned X_FIELD = 0;
  localparam int unsigned Y_FIELD = 1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RD    = 3'd1,
    ST_CHK   = 3'd2,
    ST_EMIT  = 3'd3,
    ST_FINAL = 3'd4,
    ST_DONE  = 3'd5,
    ST_ERR   = 3'd6
  } state_e;

endpackage

// File: rtl/nw_step_decode.sv
// Classifies one traceback step prev->cur into an alignment column kind.
// Any move other than a unit step up, left or diagonal is flagged bad.
module nw_step_decode
  import nw_pkg::*;
#(
  parameter int unsigned LENGTH      = 10,
  parameter int unsigned CORD_LENGTH = 8
) (
  input  logic [CORD_LENGTH-1:0] prev_x,
  input  logic [CORD_LENGTH-1:0] prev_y,
  input  logic [CORD_LENGTH-1:0] cur_x,
  input  logic [CORD_LENGTH-1:0] cur_y,
  output logic [DIR_W-1:0]       dir,
  output logic                   gap1,
  output logic                   gap2,
  output logic                   bad_step
);

  localparam int unsigned CW1 = CORD_LENGTH + 1;

  logic in_range;
  logic x_same;
  logic y_same;
  logic x_dec;
  logic y_dec;

  // Widened increment so cur+1 can never wrap onto prev.
  assign in_range = (cur_x < CORD_LENGTH'(LENGTH)) && (cur_y < CORD_LENGTH'(LENGTH));
  assign x_same   = (cur_x == prev_x);
  assign y_same   = (cur_y == prev_y);
  assign x_dec    = ((CW1'(cur_x) + CW1'(1)) == CW1'(prev_x));
  assign y_dec    = ((CW1'(cur_y) + CW1'(1)) == CW1'(prev_y));

  always_comb begin
    dir      = CORNER_DIR;
    gap1     = 1'b0;
    gap2     = 1'b0;
    bad_step = 1'b0;
    if (!in_range) begin
      bad_step = 1'b1;
    end else if (x_same && y_dec) begin
      dir  = TOP_DIR;
      gap2 = 1'b1;
    end else if (x_dec && y_same) begin
      dir  = LEFT_DIR;
      gap1 = 1'b1;
    end else if (x_dec && y_dec) begin
      dir = CORNER_DIR;
    end else begin
      bad_step = 1'b1;
    end
  end

endmodule

// File: rtl/nw_align_reader.sv
// Reads the traceback path back from memory and streams one aligned column
// per step (alignment end first), closing with the (0,0) corner column.
module nw_align_reader
  import nw_pkg::*;
#(
  parameter int unsigned LENGTH      = 10,
  parameter int unsigned CWIDTH      = 2,
  parameter int unsigned CORD_LENGTH = 8,
  parameter int unsigned MEM_SIZE    = 9,
  parameter int unsigned BYTE_SIZE   = 2 * CORD_LENGTH
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [MEM_SIZE-1:0]        path_len,
  input  logic [LENGTH*CWIDTH-1:0]   s1,
  input  logic [LENGTH*CWIDTH-1:0]   s2,
  output logic                       rd_en,
  output logic [MEM_SIZE-1:0]        raddr,
  input  logic [BYTE_SIZE-1:0]       rdata,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [CWIDTH-1:0]          out_c1,
  output logic [CWIDTH-1:0]          out_c2,
  output logic                       out_gap1,
  output logic                       out_gap2,
  output logic [DIR_W-1:0]           out_dir,
  output logic                       out_last,
  output logic                       busy,
  output logic                       done,
  output logic                       error
);

  localparam int unsigned SW      = LENGTH * CWIDTH;
  localparam int unsigned MAX_LEN = 2 * LENGTH - 1;

  state_e                 state_q, state_d;
  logic [MEM_SIZE-1:0]    idx_q, idx_d;
  logic [MEM_SIZE-1:0]    len_q;
  logic [SW-1:0]          s1_q, s2_q;
  logic [CORD_LENGTH-1:0] prev_x_q, prev_y_q, prev_x_d, prev_y_d;
  logic [CORD_LENGTH-1:0] cur_x, cur_y;

  logic                   len_ok, start_ok, start_bad, hs;
  logic [DIR_W-1:0]       dec_dir;
  logic                   dec_gap1, dec_gap2, dec_bad;
  logic [CWIDTH-1:0]      sel_c1, sel_c2;

  logic                   rd_en_d, out_valid_d, gap1_d, gap2_d, last_d;
  logic                   busy_d, done_d, error_d;
  logic [MEM_SIZE-1:0]    raddr_d;
  logic [CWIDTH-1:0]      c1_d, c2_d;
  logic [DIR_W-1:0]       dir_d;

  assign cur_x     = rdata[X_FIELD*CORD_LENGTH +: CORD_LENGTH];
  assign cur_y     = rdata[Y_FIELD*CORD_LENGTH +: CORD_LENGTH];
  assign len_ok    = (path_len != '0) && (path_len <= MEM_SIZE'(MAX_LEN));
  assign start_ok  = (state_q == ST_IDLE) && start && len_ok;
  assign start_bad = (state_q == ST_IDLE) && start && !len_ok;
  assign hs        = out_valid && out_ready;

  nw_step_decode #(
    .LENGTH      (LENGTH),
    .CORD_LENGTH (CORD_LENGTH)
  ) u_step_decode (
    .prev_x   (prev_x_q),
    .prev_y   (prev_y_q),
    .cur_x    (cur_x),
    .cur_y    (cur_y),
    .dir      (dec_dir),
    .gap1     (dec_gap1),
    .gap2     (dec_gap2),
    .bad_step (dec_bad)
  );

  // Characters at the previous cell: s1 is indexed by y, s2 by x.
  always_comb begin
    sel_c1 = '0;
    sel_c2 = '0;
    for (int unsigned i = 0; i < LENGTH; i++) begin
      if (prev_y_q == CORD_LENGTH'(i)) sel_c1 = s1_q[i*CWIDTH +: CWIDTH];
      if (prev_x_q == CORD_LENGTH'(i)) sel_c2 = s2_q[i*CWIDTH +: CWIDTH];
    end
  end

  // State register plus the registered outputs and datapath.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      len_q     <= '0;
      s1_q      <= '0;
      s2_q      <= '0;
      prev_x_q  <= '0;
      prev_y_q  <= '0;
      rd_en     <= 1'b0;
      raddr     <= '0;
      out_valid <= 1'b0;
      out_c1    <= '0;
      out_c2    <= '0;
      out_gap1  <= 1'b0;
      out_gap2  <= 1'b0;
      out_dir   <= '0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      prev_x_q  <= prev_x_d;
      prev_y_q  <= prev_y_d;
      if (start_ok) begin
        len_q <= path_len;
        s1_q  <= s1;
        s2_q  <= s2;
      end
      rd_en     <= rd_en_d;
      raddr     <= raddr_d;
      out_valid <= out_valid_d;
      out_c1    <= c1_d;
      out_c2    <= c2_d;
      out_gap1  <= gap1_d;
      out_gap2  <= gap2_d;
      out_dir   <= dir_d;
      out_last  <= last_d;
      busy      <= busy_d;
      done      <= done_d;
      error     <= error_d;
    end
  end

  // Next state, read index and previous-cell tracking.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    prev_x_d = prev_x_q;
    prev_y_d = prev_y_q;
    case (state_q)
      ST_IDLE: begin
        if (start_ok) begin
          state_d = ST_RD;
          idx_d   = '0;
        end
      end
      ST_RD: state_d = ST_CHK;
      ST_CHK: begin
        if (idx_q == '0) begin
          if ((cur_x == CORD_LENGTH'(LENGTH - 1)) && (cur_y == CORD_LENGTH'(LENGTH - 1))) begin
            prev_x_d = cur_x;
            prev_y_d = cur_y;
            if (len_q == MEM_SIZE'(1)) begin
              state_d = ST_FINAL;
            end else begin
              state_d = ST_RD;
              idx_d   = MEM_SIZE'(1);
            end
          end else begin
            state_d = ST_ERR;
          end
        end else if (dec_bad) begin
          state_d = ST_ERR;
        end else begin
          prev_x_d = cur_x;
          prev_y_d = cur_y;
          state_d  = ST_EMIT;
        end
      end
      ST_EMIT: begin
        if (hs) begin
          if ((idx_q + MEM_SIZE'(1)) < len_q) begin
            state_d = ST_RD;
            idx_d   = idx_q + MEM_SIZE'(1);
          end else if ((prev_x_q == '0) && (prev_y_q == '0)) begin
            state_d = ST_FINAL;
          end else begin
            state_d = ST_ERR;
          end
        end
      end
      ST_FINAL: if (hs) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      ST_ERR:   state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs, decoded from the next state.
  always_comb begin
    rd_en_d     = 1'b0;
    raddr_d     = '0;
    out_valid_d = 1'b0;
    c1_d        = '0;
    c2_d        = '0;
    gap1_d      = 1'b0;
    gap2_d      = 1'b0;
    dir_d       = '0;
    last_d      = 1'b0;
    busy_d      = (state_d != ST_IDLE);
    done_d      = start_bad || (state_d == ST_DONE) || (state_d == ST_ERR);
    error_d     = error;
    if (start_ok) error_d = 1'b0;
    if (start_bad || (state_d == ST_ERR)) error_d = 1'b1;
    case (state_d)
      ST_RD: begin
        rd_en_d = 1'b1;
        raddr_d = idx_d;
      end
      ST_EMIT: begin
        out_valid_d = 1'b1;
        if (state_q == ST_CHK) begin
          c1_d   = dec_gap1 ? '0 : sel_c1;
          c2_d   = dec_gap2 ? '0 : sel_c2;
          gap1_d = dec_gap1;
          gap2_d = dec_gap2;
          dir_d  = dec_dir;
        end else begin
          c1_d   = out_c1;
          c2_d   = out_c2;
          gap1_d = out_gap1;
          gap2_d = out_gap2;
          dir_d  = out_dir;
        end
      end
      ST_FINAL: begin
        out_valid_d = 1'b1;
        c1_d        = s1_q[CWIDTH-1:0];
        c2_d        = s2_q[CWIDTH-1:0];
        dir_d       = CORNER_DIR;
        last_d      = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_nw_align_reader.sv
// Directed bench for nw_align_reader: a scoreboard queue of expected columns
// is filled when each read-back is started and drained as columns are accepted.
module tb_nw_align_reader;

  localparam int unsigned LENGTH   = 3;
  localparam int unsigned CWIDTH   = 2;
  localparam int unsigned CORD     = 8;
  localparam int unsigned MEM_SIZE = 9;
  localparam int unsigned BYTE_W   = 2 * CORD;
  localparam int unsigned SW       = LENGTH * CWIDTH;

  localparam logic [1:0] A = 2'd0, C = 2'd1, G = 2'd2, T = 2'd3;
  localparam logic [1:0] D_TOP = 2'b00, D_LEFT = 2'b01, D_CORNER = 2'b10;
  localparam logic [SW-1:0] STR_ACG = {G, C, A};
  localparam logic [SW-1:0] STR_ATC = {C, T, A};

  typedef struct packed {
    logic [1:0] c1;
    logic [1:0] c2;
    logic       g1;
    logic       g2;
    logic [1:0] dir;
    logic       last;
  } col_t;

  logic                clk;
  logic                reset;
  logic                start;
  logic [MEM_SIZE-1:0] path_len;
  logic [SW-1:0]       s1, s2;
  logic                rd_en;
  logic [MEM_SIZE-1:0] raddr;
  logic [BYTE_W-1:0]   rdata;
  logic                out_valid, out_ready;
  logic [CWIDTH-1:0]   out_c1, out_c2;
  logic                out_gap1, out_gap2;
  logic [1:0]          out_dir;
  logic                out_last, busy, done, error;

  logic [BYTE_W-1:0]   mem [0:(1<<MEM_SIZE)-1];
  col_t                exp_q[$];
  int                  checks = 0;
  int                  errors = 0;
  int                  done_cnt = 0;
  int                  valid_cnt = 0;

  nw_align_reader #(
    .LENGTH      (LENGTH),
    .CWIDTH      (CWIDTH),
    .CORD_LENGTH (CORD),
    .MEM_SIZE    (MEM_SIZE),
    .BYTE_SIZE   (BYTE_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .path_len  (path_len),
    .s1        (s1),
    .s2        (s2),
    .rd_en     (rd_en),
    .raddr     (raddr),
    .rdata     (rdata),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_c1    (out_c1),
    .out_c2    (out_c2),
    .out_gap1  (out_gap1),
    .out_gap2  (out_gap2),
    .out_dir   (out_dir),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done),
    .error     (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_ff @(posedge clk) if (rd_en) rdata <= mem[raddr];

  always @(negedge clk) begin
    if (done) done_cnt <= done_cnt + 1;
    if (out_valid) valid_cnt <= valid_cnt + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic col_t mk(input logic [1:0] c1, input logic [1:0] c2, input logic g1,
                              input logic g2, input logic [1:0] d, input logic last);
    col_t c;
    c.c1 = c1; c.c2 = c2; c.g1 = g1; c.g2 = g2; c.dir = d; c.last = last;
    return c;
  endfunction

  function automatic col_t dut_col();
    col_t c;
    c.c1 = out_c1; c.c2 = out_c2; c.g1 = out_gap1; c.g2 = out_gap2;
    c.dir = out_dir; c.last = out_last;
    return c;
  endfunction

  task automatic set_word(input int a, input int x, input int y);
    mem[a] = {CORD'(y), CORD'(x)};
  endtask

  task automatic load_diag();
    set_word(0, 2, 2); set_word(1, 1, 1); set_word(2, 0, 0);
  endtask

  task automatic push_diag();
    exp_q.push_back(mk(G, G, 1'b0, 1'b0, D_CORNER, 1'b0));
    exp_q.push_back(mk(C, C, 1'b0, 1'b0, D_CORNER, 1'b0));
    exp_q.push_back(mk(A, A, 1'b0, 1'b0, D_CORNER, 1'b1));
  endtask

  // Entered and left on a falling edge.
  task automatic do_start(input int len, input logic [SW-1:0] a, input logic [SW-1:0] b);
    path_len = MEM_SIZE'(len);
    s1 = a;
    s2 = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int t = 0; t < 60; t++) begin
      if (out_valid) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic run_cols(input int n, input int stall_at);
    bit   ok;
    col_t exp_c;
    for (int k = 0; k < n; k++) begin
      if (k == stall_at) out_ready = 1'b0;
      wait_valid(ok);
      chk($sformatf("col%0d_valid", k), 32'(ok), 32'd1);
      if (!ok) return;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL col%0d observed=%0h expected=none", k, 32'(dut_col()));
      end else begin
        exp_c = exp_q.pop_front();
        chk($sformatf("col%0d_payload", k), 32'(dut_col()), 32'(exp_c));
        if (k == stall_at) begin
          for (int s = 0; s < 5; s++) begin
            @(negedge clk);
            chk("stall_valid", 32'(out_valid), 32'd1);
            chk("stall_payload", 32'(dut_col()), 32'(exp_c));
            chk("stall_rd_en", 32'(rd_en), 32'd0);
          end
          out_ready = 1'b1;
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic finish_run();
    chk("done_pulse", 32'(done), 32'd1);
    chk("valid_after_last", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk("done_clear", 32'(done), 32'd0);
    chk("busy_idle", 32'(busy), 32'd0);
  endtask

  task automatic err_case(input string tag, input int len);
    int d0, v0;
    d0 = done_cnt;
    v0 = valid_cnt;
    do_start(len, STR_ACG, STR_ACG);
    repeat (20) @(negedge clk);
    chk({tag, "_error"}, 32'(error), 32'd1);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done_pulses"}, 32'(done_cnt - d0), 32'd1);
    chk({tag, "_no_valid"}, 32'(valid_cnt - v0), 32'd0);
  endtask

  initial begin
    bit ok;
    int d0;
    reset = 1'b1;
    start = 1'b0;
    path_len = '0;
    s1 = '0;
    s2 = '0;
    out_ready = 1'b1;
    for (int i = 0; i < (1 << MEM_SIZE); i++) mem[i] = '0;
    repeat (3) @(negedge clk);
    chk("rst_outputs", {rd_en, raddr, out_valid, out_c1, out_c2, out_gap1, out_gap2,
                        out_dir, out_last, busy, done, error}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Diagonal path: three corner columns.
    load_diag();
    push_diag();
    do_start(3, STR_ACG, STR_ACG);
    chk("first_rd_en", 32'(rd_en), 32'd1);
    chk("first_raddr", 32'(raddr), 32'd0);
    chk("busy_run", 32'(busy), 32'd1);
    run_cols(3, -1);
    finish_run();
    chk("diag_error", 32'(error), 32'd0);

    // Mixed path: TOP, CORNER, LEFT, final corner.
    set_word(0, 2, 2); set_word(1, 2, 1); set_word(2, 1, 0); set_word(3, 0, 0);
    exp_q.push_back(mk(G, 2'd0, 1'b0, 1'b1, D_TOP,    1'b0));
    exp_q.push_back(mk(C, C,    1'b0, 1'b0, D_CORNER, 1'b0));
    exp_q.push_back(mk(2'd0, T, 1'b1, 1'b0, D_LEFT,   1'b0));
    exp_q.push_back(mk(A, A,    1'b0, 1'b0, D_CORNER, 1'b1));
    do_start(4, STR_ACG, STR_ATC);
    run_cols(4, -1);
    finish_run();

    // Backpressure on the second column.
    load_diag();
    push_diag();
    do_start(3, STR_ACG, STR_ACG);
    run_cols(3, 1);
    finish_run();

    // Error paths.
    set_word(0, 2, 2); set_word(1, 0, 0);
    err_case("jump", 2);
    set_word(0, 1, 2);
    err_case("bad_first", 3);
    err_case("len_zero", 0);

    // A good start clears the sticky error.
    load_diag();
    push_diag();
    do_start(3, STR_ACG, STR_ACG);
    chk("error_cleared", 32'(error), 32'd0);
    run_cols(3, -1);
    finish_run();

    // Reset while column 2 is held in EMIT.
    load_diag();
    push_diag();
    do_start(3, STR_ACG, STR_ACG);
    run_cols(1, -1);
    out_ready = 1'b0;
    wait_valid(ok);
    chk("rst_hold_valid", 32'(ok), 32'd1);
    d0 = done_cnt;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midrst_outputs", {rd_en, raddr, out_valid, out_c1, out_c2, out_gap1, out_gap2,
                           out_dir, out_last, busy, done, error}, 32'd0);
    out_ready = 1'b1;
    repeat (10) @(negedge clk);
    chk("midrst_no_done", 32'(done_cnt - d0), 32'd0);
    chk("midrst_idle", 32'(busy), 32'd0);
    exp_q.delete();

    // Fresh run after the abort.
    push_diag();
    do_start(3, STR_ACG, STR_ACG);
    run_cols(3, -1);
    finish_run();

    // A second start while busy (with an illegal length) is ignored.
    push_diag();
    do_start(3, STR_ACG, STR_ACG);
    path_len = '0;
    s1 = '1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    path_len = MEM_SIZE'(3);
    run_cols(3, -1);
    finish_run();
    chk("restart_error", 32'(error), 32'd0);
    chk("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
